// File: rtl/sd_cmd.sv
// sd_cmd: SD card CMD-line engine.
// Shifts out a 48-bit command frame (start, transmission bit, index, argument,
// CRC7, end), then optionally waits for and receives a 48-bit or 136-bit
// response, and finally holds the line idle for a fixed number of SD clocks.
// SD clock timing comes in as one-cycle strobes on the system clock: the pad
// output changes on falling strobes, and the pad input is sampled on rising strobes.
//
// Ports
//   i_clk, i_reset                   system clock, async active-high reset
//   i_sd_clk_rising/_falling         SD clock edge strobes
//   i_sd_cmd_in                      synchronized CMD pad input
//   o_sd_cmd_oe, o_sd_cmd_out        CMD pad drive
//   i_command_*                      command request (start pulse + fields)
//   o_command_busy                   transaction in progress
//   o_command_timeout                response start bit absent for P_TIMEOUT strobes
//   o_command_response_crc_error     bad response CRC7 or end bit
//   o_command_index/_response        last received response fields
//
// state  | meaning
// IDLE   | ready, accepts i_command_start
// TX     | shifting the command frame out on falling strobes
// WAIT   | line released, looking for a response start bit
// RX     | shifting response bits in on rising strobes
// GAP    | idle line for P_GAP SD clocks before going IDLE
module sd_cmd #(
    parameter int P_TIMEOUT = 64,
    parameter int P_GAP     = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sd_clk_rising,
    input  logic        i_sd_clk_falling,
    input  logic        i_sd_cmd_in,
    output logic        o_sd_cmd_oe,
    output logic        o_sd_cmd_out,
    input  logic        i_command_start,
    input  logic [5:0]  i_command_index,
    input  logic [31:0] i_command_argument,
    input  logic        i_command_long_response,
    input  logic        i_command_skip_response,
    output logic        o_command_busy,
    output logic        o_command_timeout,
    output logic        o_command_response_crc_error,
    output logic [5:0]  o_command_index,
    output logic [31:0] o_command_response
);

    localparam int C_MAX_A = (P_TIMEOUT > 136) ? P_TIMEOUT : 136;
    localparam int C_MAX   = (P_GAP > C_MAX_A) ? P_GAP : C_MAX_A;
    localparam int C_CNT_W = $clog2(C_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_GAP} state_t;

    state_t               r_state, w_state;
    logic [C_CNT_W-1:0]   r_count, w_count;
    logic [47:0]          r_frame, w_frame;
    logic [47:0]          r_rx, w_rx;
    logic                 r_long, w_long;
    logic                 r_skip, w_skip;
    logic                 r_oe, w_oe;
    logic                 r_out, w_out;
    logic                 r_timeout, w_timeout;
    logic                 r_crc_error, w_crc_error;
    logic [5:0]           r_index, w_index;
    logic [31:0]          r_response, w_response;

    logic [39:0]          w_tx_head;
    logic [6:0]           w_tx_crc;
    logic [47:0]          w_rx_shift;
    logic [6:0]           w_rx_crc;

    // Serial CRC7 (x^7 + x^3 + 1), zero seed, MSB first.
    function automatic logic [6:0] f_crc7(input logic [39:0] i_data);
        logic [6:0] v_crc;
        logic       v_fb;
        v_crc = '0;
        for (int i = 39; i >= 0; i--) begin
            v_fb  = i_data[i] ^ v_crc[6];
            v_crc = {v_crc[5:0], 1'b0} ^ (v_fb ? 7'h09 : 7'h00);
        end
        return v_crc;
    endfunction

    assign w_tx_head  = {2'b01, i_command_index, i_command_argument};
    assign w_tx_crc   = f_crc7(w_tx_head);
    // Response register as it will look once the bit on the line is shifted in.
    assign w_rx_shift = {r_rx[46:0], i_sd_cmd_in};
    assign w_rx_crc   = f_crc7(w_rx_shift[47:8]);

    always_comb begin
        w_state     = r_state;
        w_count     = r_count;
        w_frame     = r_frame;
        w_rx        = r_rx;
        w_long      = r_long;
        w_skip      = r_skip;
        w_oe        = r_oe;
        w_out       = r_out;
        w_timeout   = r_timeout;
        w_crc_error = r_crc_error;
        w_index     = r_index;
        w_response  = r_response;
        case (r_state)
            S_IDLE: begin
                if (i_command_start) begin
                    w_state     = S_TX;
                    w_frame     = {w_tx_head, w_tx_crc, 1'b1};
                    w_count     = C_CNT_W'(48);
                    w_long      = i_command_long_response;
                    w_skip      = i_command_skip_response;
                    w_timeout   = 1'b0;
                    w_crc_error = 1'b0;
                end
            end
            S_TX: begin
                if (i_sd_clk_falling) begin
                    if (r_count != '0) begin
                        w_oe    = 1'b1;
                        w_out   = r_frame[47];
                        w_frame = {r_frame[46:0], 1'b1};
                        w_count = r_count - 1'b1;
                    end else begin
                        // One extra falling edge after the end bit releases the line.
                        w_oe  = 1'b0;
                        w_out = 1'b1;
                        if (r_skip) begin
                            w_state = S_GAP;
                            w_count = C_CNT_W'(P_GAP - 1);
                        end else begin
                            w_state = S_WAIT;
                            w_count = C_CNT_W'(P_TIMEOUT - 1);
                        end
                    end
                end
            end
            S_WAIT: begin
                if (i_sd_clk_rising) begin
                    if (!i_sd_cmd_in) begin
                        w_state = S_RX;
                        w_rx    = w_rx_shift;
                        w_count = r_long ? C_CNT_W'(134) : C_CNT_W'(46);
                    end else if (r_count == '0) begin
                        w_timeout = 1'b1;
                        w_state   = S_GAP;
                        w_count   = C_CNT_W'(P_GAP - 1);
                    end else begin
                        w_count = r_count - 1'b1;
                    end
                end
            end
            S_RX: begin
                if (i_sd_clk_rising) begin
                    w_rx = w_rx_shift;
                    if (r_count == '0) begin
                        w_state    = S_GAP;
                        w_count    = C_CNT_W'(P_GAP - 1);
                        w_response = w_rx_shift[39:8];
                        if (r_long) begin
                            // R2 carries its own internal CRC; only the end bit is checked.
                            w_index     = 6'h3F;
                            w_crc_error = ~w_rx_shift[0];
                        end else begin
                            w_index     = w_rx_shift[45:40];
                            w_crc_error = (w_rx_shift[7:1] != w_rx_crc) || !w_rx_shift[0];
                        end
                    end else begin
                        w_count = r_count - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (i_sd_clk_rising) begin
                    if (r_count == '0) begin
                        w_state = S_IDLE;
                    end else begin
                        w_count = r_count - 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_frame     <= '0;
            r_rx        <= '0;
            r_long      <= 1'b0;
            r_skip      <= 1'b0;
            r_oe        <= 1'b0;
            r_out       <= 1'b1;
            r_timeout   <= 1'b0;
            r_crc_error <= 1'b0;
            r_index     <= '0;
            r_response  <= '0;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_frame     <= w_frame;
            r_rx        <= w_rx;
            r_long      <= w_long;
            r_skip      <= w_skip;
            r_oe        <= w_oe;
            r_out       <= w_out;
            r_timeout   <= w_timeout;
            r_crc_error <= w_crc_error;
            r_index     <= w_index;
            r_response  <= w_response;
        end
    end

    assign o_sd_cmd_oe                  = r_oe;
    assign o_sd_cmd_out                 = r_out;
    assign o_command_busy               = (r_state != S_IDLE);
    assign o_command_timeout            = r_timeout;
    assign o_command_response_crc_error = r_crc_error;
    assign o_command_index              = r_index;
    assign o_command_response           = r_response;

endmodule

// File: tb/tb_sd_cmd.sv
// Bench for sd_cmd: a card model answers each command, a bus process records
// what the DUT puts on the pad, and a monitor compares every finished
// transaction against expectations queued when the command was issued.
module tb_sd_cmd;
    localparam int P_TIMEOUT = 64;
    localparam int P_GAP     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rise = 1'b0, fall = 1'b0;
    logic        cmd_in = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  c_idx = '0;
    logic [31:0] c_arg = '0;
    logic        c_long = 1'b0, c_skip = 1'b0;
    logic        oe, out, busy, tmo, crce;
    logic [5:0]  ridx;
    logic [31:0] rresp;

    sd_cmd #(.P_TIMEOUT(P_TIMEOUT), .P_GAP(P_GAP)) dut (
        .i_clk                        (clk),
        .i_reset                      (rst),
        .i_sd_clk_rising              (rise),
        .i_sd_clk_falling             (fall),
        .i_sd_cmd_in                  (cmd_in),
        .o_sd_cmd_oe                  (oe),
        .o_sd_cmd_out                 (out),
        .i_command_start              (start),
        .i_command_index              (c_idx),
        .i_command_argument           (c_arg),
        .i_command_long_response      (c_long),
        .i_command_skip_response      (c_skip),
        .o_command_busy               (busy),
        .o_command_timeout            (tmo),
        .o_command_response_crc_error (crce),
        .o_command_index              (ridx),
        .o_command_response           (rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] frame;
        logic        tmo;
        logic        crce;
        logic [5:0]  idx;
        logic [31:0] resp;
    } exp_t;

    typedef struct {
        logic [47:0] frame;
        int          nbits;
        logic        tmo;
        logic        crce;
        logic [5:0]  idx;
        logic [31:0] resp;
        int          tmo_at;
        int          gap;
    } obs_t;

    exp_t sbq[$];
    obs_t obsq[$];
    logic card_q[$];
    int   card_dly = 0;

    int checks = 0;
    int passes = 0;

    logic [5:0]  model_idx = '0;
    logic [31:0] model_resp = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    // ---------------- SD bus: strobes, pad capture, card ----------------
    logic [47:0] cap = '0;
    int  cap_n = 0;
    bit  tx_done = 0;
    int  rises_wait = 0;
    int  gap_cnt = 0;
    int  tmo_at = -1;
    bit  last_pend = 0;
    bit  prev_rise = 0, prev_fall = 0, prev_busy = 0, prev_tmo = 0;
    bit  next_rise = 1;
    int  hp = 1;

    always @(negedge clk) begin
        obs_t o;
        if (rst) begin
            cap_n = 0; tx_done = 0; tmo_at = -1; last_pend = 0;
            card_q.delete(); card_dly = 0; cmd_in = 1'b1;
            prev_busy = 0; prev_tmo = 0;
        end else begin
            if (prev_fall && !tx_done) begin
                if (oe) begin
                    cap = {cap[46:0], out};
                    cap_n++;
                end else if (cap_n > 0) begin
                    tx_done = 1; rises_wait = 0; gap_cnt = 0;
                end
            end
            if (prev_rise) begin
                gap_cnt++;
                if (tx_done) rises_wait++;
                if (last_pend) begin last_pend = 0; gap_cnt = 0; end
            end
            if (tx_done && tmo && !prev_tmo) begin
                tmo_at = rises_wait; gap_cnt = 0;
            end
            if (prev_busy && !busy) begin
                o.frame = cap; o.nbits = cap_n; o.tmo = tmo; o.crce = crce;
                o.idx = ridx; o.resp = rresp; o.tmo_at = tmo_at; o.gap = gap_cnt;
                obsq.push_back(o);
                cap_n = 0; tx_done = 0; tmo_at = -1; cap = '0;
            end
            prev_busy = busy;
            prev_tmo  = tmo;
        end
        rise = 1'b0; fall = 1'b0;
        if (hp == 0) begin
            if (next_rise) rise = 1'b1; else fall = 1'b1;
            next_rise = !next_rise;
            hp = $urandom_range(1, 3);
        end else begin
            hp--;
        end
        if (rise && !rst) begin
            if (tx_done && card_dly > 0) begin
                cmd_in = 1'b1; card_dly--;
            end else if (tx_done && card_q.size() > 0) begin
                cmd_in = card_q.pop_front();
                if (card_q.size() == 0) last_pend = 1;
            end else begin
                cmd_in = 1'b1;
            end
        end
        prev_rise = rise;
        prev_fall = fall;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            while (obsq.size() > 0) begin
                obs_t o;
                exp_t e;
                o = obsq.pop_front();
                check("sb_has_expectation", (sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("tx_frame", o.frame, e.frame);
                    check("tx_oe_bits", o.nbits, 48);
                    check("timeout", o.tmo, e.tmo);
                    check("crc_error", o.crce, e.crce);
                    check("resp_index", o.idx, e.idx);
                    check("response", o.resp, e.resp);
                    check("gap_strobes", o.gap, P_GAP);
                    check("timeout_strobe", o.tmo_at, e.tmo ? P_TIMEOUT : -1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        check("idle_wait", busy, 0);
        @(negedge clk);
    endtask

    // mode: 0 silent card, 1 good short, 2 short bad CRC, 3 short end bit 0,
    //       4 good long, 5 long end bit 0
    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input bit skp,
                         input int mode, input int dly, input logic [5:0] r_idx,
                         input logic [31:0] r_pay, input bit dup, input bit push,
                         input bit use_const, input logic [47:0] frame_const);
        exp_t        e;
        logic [39:0] h;
        logic [6:0]  c;
        logic        eb;
        logic        lb [136];
        logic [31:0] r;
        wait_idle();
        e.frame = use_const ? frame_const
                            : {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
        e.tmo = 1'b0; e.crce = 1'b0;
        e.idx = model_idx; e.resp = model_resp;
        card_q.delete();
        card_dly = dly;
        if (mode == 0) begin
            e.tmo = !skp;
        end else if (mode <= 3) begin
            h  = {2'b00, r_idx, r_pay};
            c  = ref_crc7(h);
            eb = 1'b1;
            if (mode == 2) c = c ^ (7'd1 << $urandom_range(0, 6));
            if (mode == 3) eb = 1'b0;
            for (int i = 39; i >= 0; i--) card_q.push_back(h[i]);
            for (int i = 6; i >= 0; i--) card_q.push_back(c[i]);
            card_q.push_back(eb);
            e.idx = r_idx; e.resp = r_pay; e.crce = (mode != 1);
        end else begin
            for (int i = 0; i < 136; i++) lb[i] = 1'($urandom_range(0, 1));
            lb[0] = 1'b0; lb[1] = 1'b0;
            for (int i = 2; i < 8; i++) lb[i] = 1'b1;
            lb[135] = (mode == 4);
            for (int i = 0; i < 136; i++) card_q.push_back(lb[i]);
            r = '0;
            for (int k = 96; k < 128; k++) r = {r[30:0], lb[k]};
            e.idx = 6'h3F; e.resp = r; e.crce = (mode == 5);
        end
        model_idx = e.idx; model_resp = e.resp;
        if (push) sbq.push_back(e);
        c_idx = idx; c_arg = arg; c_long = (mode >= 4); c_skip = skp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("timeout_cleared", tmo, 0);
        check("crc_error_cleared", crce, 0);
        c_idx = 6'($urandom); c_arg = $urandom;
        if (dup) begin
            repeat (20) @(negedge clk);
            c_idx = ~idx; c_arg = ~arg; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int n;
        int mode;
        bit skp;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_oe", oe, 0);
        check("rst_out", out, 1);
        check("rst_busy", busy, 0);
        check("rst_timeout", tmo, 0);
        check("rst_crc_error", crce, 0);
        check("rst_index", ridx, 0);
        check("rst_response", rresp, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CMD0, no response
        issue(6'd0, 32'h0, 1, 0, 0, 6'd0, 32'h0, 0, 1, 1, 48'h400000000095);
        // CMD8 with R7 echo after 5 strobes, plus an ignored start mid-frame
        issue(6'd8, 32'h000001AA, 0, 1, 5, 6'd8, 32'h000001AA, 1, 1, 1, 48'h48000001AA87);
        // CMD55 with silent card
        issue(6'd55, 32'h0, 0, 0, 0, 6'd0, 32'h0, 0, 1, 0, 48'h0);
        // corrupted CRC, corrupted end bit, then a clean response
        issue(6'd13, $urandom, 0, 2, 3, 6'd13, $urandom, 0, 1, 0, 48'h0);
        issue(6'd13, $urandom, 0, 3, 2, 6'd13, $urandom, 0, 1, 0, 48'h0);
        issue(6'd13, $urandom, 0, 1, 1, 6'd13, $urandom, 0, 1, 0, 48'h0);
        // CMD2 long response
        issue(6'd2, 32'h0, 0, 4, 4, 6'd0, 32'h0, 0, 1, 0, 48'h0);

        for (int t = 0; t < 16; t++) begin
            mode = $urandom_range(0, 5);
            skp  = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue(6'($urandom), $urandom, skp, mode, $urandom_range(0, 20),
                  6'($urandom), $urandom, ($urandom_range(0, 3) == 0), 1, 0, 48'h0);
        end

        // Reset in the middle of a command frame
        issue(6'd17, $urandom, 0, 1, 2, 6'd17, $urandom, 0, 0, 0, 48'h0);
        n = 0;
        while (cap_n < 20 && n < 2000) begin @(negedge clk); n++; end
        check("reached_tx_bit20", (cap_n >= 20), 1);
        check("oe_before_reset", oe, 1);
        rst = 1'b1;
        #1;
        check("abort_oe", oe, 0);
        check("abort_out", out, 1);
        check("abort_busy", busy, 0);
        check("abort_index", ridx, 0);
        check("abort_response", rresp, 0);
        model_idx = '0; model_resp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(6'd0, 32'h0, 1, 0, 0, 6'd0, 32'h0, 0, 1, 1, 48'h400000000095);

        wait_idle();
        repeat (10) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
